rr_mux_sel_ctrl: RTL and testbench
==================================

Name: rr_mux_sel_ctrl

Overview:
- Round-robin select controller sitting directly upstream of the 4-way 16-bit mux; drives its S1/S2 selects.
- Four requesters (channels 0..3 map to mux inputs I1..I4) compete for the shared 16-bit path.
- Grants one channel at a time, holds the grant for a burst of beats under a valid/ready handshake with the downstream consumer, then rotates priority.

Parameters:
- MAX_BEATS, 4, maximum beats per grant before forced release; legal range 1..255.
- CNT_W, 8, width of the beat counter; must hold MAX_BEATS-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-channel request; bit n = channel n.
- last  input  1  current granted channel marks this beat as final.
- ready  input  1  downstream consumer accepts the beat this cycle.
- grant  output  4  one-hot grant, or all zero when idle.
- s1  output  1  mux select S1 = channel index bit 0.
- s2  output  1  mux select S2 = channel index bit 1.
- valid  output  1  a granted channel is presenting a beat.
- beat_cnt  output  CNT_W  beats transferred in the current grant.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: grant=0, valid=0, s1=0, s2=0, beat_cnt=0, priority pointer ptr=0, state IDLE.
- Reset asserted mid-burst aborts the burst immediately and restores these values; no beat is counted.
- All outputs are registered.
- Channel mapping:
  - ch0: S2=0, S1=0 (I1)
  - ch1: S2=0, S1=1 (I2)
  - ch2: S2=1, S1=0 (I3)
  - ch3: S2=1, S1=1 (I4)
- Arbitration: choose the first set req bit scanning ptr, ptr+1, ... mod 4.
- State IDLE:
  - valid=0, grant=0.
  - s1/s2 hold their last values.
  - If req!=0, arbitrate. Next cycle: grant one-hot, s1/s2 = winner index, valid=1, beat_cnt=0, go to BUSY.
  - Latency from req to grant is 1 cycle.
- State BUSY, current channel cur:
  - transfer = valid & ready. On transfer, beat_cnt increments.
  - Release when any of these holds:
    - transfer & last
    - transfer & beat_cnt==MAX_BEATS-1
    - req[cur]==0 (requester withdrew; no beat is counted unless transfer is also high that cycle)
  - On release: ptr = cur+1 mod 4.
  - Re-arbitrate in the same cycle over req with cur masked out, using the new ptr.
    - Winner found: new grant is visible next cycle (back-to-back, no idle bubble), beat_cnt=0.
    - No winner: go to IDLE.
- If only cur is requesting at release, cur is not re-granted that cycle. The controller goes to IDLE and re-grants cur one cycle later, so there is a one-cycle bubble.
- ready with valid=0 has no effect.
- last without transfer is ignored.
- MAX_BEATS=1: every transfer releases.
- beat_cnt never exceeds MAX_BEATS-1 and never wraps.
- Requests for non-granted channels arriving mid-burst are only sampled at release.

Test Plan:
- Reset: assert rst asynchronously mid-cycle during a BUSY burst -> grant=0, valid=0, s1=s2=0, beat_cnt=0 immediately, without waiting for a clock edge.
- Single requester: req=0100, ready=1, last=0, MAX_BEATS=4 -> grant=0100, s2=1, s1=0 one cycle later. Four transfers, with beat_cnt 0,1,2,3. Then a one-cycle bubble (IDLE) and re-grant of ch2.
- Rotation: req=1111 held, ready=1, last=1 every beat -> grants cycle ch0, ch1, ch2, ch3, ch0 on consecutive cycles, with s2:s1 = 00, 01, 10, 11, 00.
- Backpressure: grant ch1, ready=0 for 5 cycles -> valid stays 1, beat_cnt stays 0, grant unchanged. Then ready=1 with last=1 -> release, next channel granted.
- Withdrawal: grant ch3 at beat_cnt=2, req[3] drops with ready=0, req=0001 -> next cycle grant=0001, s1=s2=0, beat_cnt=0. ptr is 0, so ch0 wins.
- Boundary: MAX_BEATS=1, req=0011, ready=1 -> strict alternation ch0, ch1, ch0, ch1, each grant lasting exactly 1 beat.

Source files
------------

// File: rtl/rr_mux_sel_ctrl.sv
// Round-robin select controller for a 4-way 16-bit mux.
// Grants one of four requesters at a time, holds the grant for a burst of
// valid/ready beats, then rotates priority. Drives the mux S1/S2 selects.
module rr_mux_sel_ctrl #(
  parameter int MAX_BEATS = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic             last,
  input  logic             ready,
  output logic [3:0]       grant,
  output logic             s1,
  output logic             s2,
  output logic             valid,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       cur_q, cur_d;
  logic [3:0]       grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             xfer;
  logic             at_max;
  logic             rel;
  logic [1:0]       nxt_ptr;
  logic [2:0]       win_idle;
  logic [2:0]       win_busy;

  // First set request bit scanning p, p+1, ... mod 4.
  // Returns {found, index}; scanning downward lets the lowest offset win.
  function automatic logic [2:0] arb(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Next-state: arbitration, burst accounting and release/re-grant decision.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cur_d    = cur_q;
    grant_d  = grant_q;
    valid_d  = valid_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;

    xfer     = valid_q & ready;
    at_max   = (cnt_q == CNT_W'(MAX_BEATS - 1));
    rel      = (xfer & (last | at_max)) | ~req[cur_q];
    nxt_ptr  = cur_q + 2'd1;
    win_idle = arb(req, ptr_q);
    // The releasing channel is masked so it cannot immediately win again.
    win_busy = arb(req & ~(4'b0001 << cur_q), nxt_ptr);

    case (state_q)
      IDLE: begin
        grant_d = 4'b0000;
        valid_d = 1'b0;
        if (win_idle[2]) begin
          state_d = BUSY;
          cur_d   = win_idle[1:0];
          sel_d   = win_idle[1:0];
          grant_d = 4'b0001 << win_idle[1:0];
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (rel) begin
          ptr_d = nxt_ptr;
          cnt_d = '0;
          if (win_busy[2]) begin
            cur_d   = win_busy[1:0];
            sel_d   = win_busy[1:0];
            grant_d = 4'b0001 << win_busy[1:0];
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
            valid_d = 1'b0;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  // Controller state and registered outputs; reset aborts any burst at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cur_q   <= 2'd0;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant    = grant_q;
  assign valid    = valid_q;
  assign s1       = sel_q[0];
  assign s2       = sel_q[1];
  assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_rr_mux_sel_ctrl.sv
// Directed bench for rr_mux_sel_ctrl: one instance with MAX_BEATS=4 and a
// second with MAX_BEATS=1 for the single-beat boundary.
module tb_rr_mux_sel_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] req,  req1;
  logic       last, last1;
  logic       ready, ready1;
  logic [3:0] grant, grant1;
  logic       s1, s2, s1_1, s2_1;
  logic       valid, valid1;
  logic [7:0] beat_cnt, beat_cnt1;

  int checks;
  int failures;

  rr_mux_sel_ctrl #(.MAX_BEATS(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .ready(ready),
    .grant(grant), .s1(s1), .s2(s2), .valid(valid), .beat_cnt(beat_cnt)
  );

  rr_mux_sel_ctrl #(.MAX_BEATS(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .last(last1), .ready(ready1),
    .grant(grant1), .s1(s1_1), .s2(s2_1), .valid(valid1), .beat_cnt(beat_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0; last = 1'b0; ready = 1'b0;
    req1 = 4'b0; last1 = 1'b0; ready1 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant !== 4'b0) begin failures++; $display("FAIL rst_grant got=%b exp=0000", grant); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid); end
    checks++; if ({s2, s1} !== 2'b00) begin failures++; $display("FAIL rst_sel got=%b exp=00", {s2, s1}); end
    checks++; if (beat_cnt !== 8'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", beat_cnt); end
    // Build a burst on ch2 up to beat_cnt=2, then reset mid-cycle.
    req = 4'b0100; ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (beat_cnt !== 8'd2 || grant !== 4'b0100) begin failures++;
      $display("FAIL rst_pre_burst got=%0d/%b exp=2/0100", beat_cnt, grant); end
    #3 rst = 1'b1;
    #1;
    checks++; if (grant !== 4'b0) begin failures++; $display("FAIL rst_async_grant got=%b exp=0000", grant); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", valid); end
    checks++; if ({s2, s1} !== 2'b00) begin failures++; $display("FAIL rst_async_sel got=%b exp=00", {s2, s1}); end
    checks++; if (beat_cnt !== 8'd0) begin failures++; $display("FAIL rst_async_cnt got=%0d exp=0", beat_cnt); end
    tick();
    rst = 1'b0;
    req = 4'b0; ready = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; ready = 1'b1; last = 1'b0;
    tick();
    checks++; if (grant !== 4'b0100 || {s2, s1} !== 2'b10 || valid !== 1'b1) begin failures++;
      $display("FAIL single_grant got=%b sel=%b v=%b exp=0100 sel=10 v=1", grant, {s2, s1}, valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (beat_cnt !== 8'(i) || grant !== 4'b0100) begin failures++;
        $display("FAIL single_cnt%0d got=%0d/%b exp=%0d/0100", i, beat_cnt, grant, i); end
      if (i < 3) tick();
    end
    tick();
    checks++; if (grant !== 4'b0 || valid !== 1'b0 || beat_cnt !== 8'd0 || {s2, s1} !== 2'b10) begin failures++;
      $display("FAIL single_bubble got=%b v=%b c=%0d sel=%b exp=0000 v=0 c=0 sel=10", grant, valid, beat_cnt, {s2, s1}); end
    tick();
    checks++; if (grant !== 4'b0100 || valid !== 1'b1 || beat_cnt !== 8'd0) begin failures++;
      $display("FAIL single_regrant got=%b v=%b c=%0d exp=0100 v=1 c=0", grant, valid, beat_cnt); end
  endtask

  task automatic test_rotation();
    logic [3:0] eg [0:4];
    logic [1:0] es [0:4];
    eg[0] = 4'b0001; eg[1] = 4'b0010; eg[2] = 4'b0100; eg[3] = 4'b1000; eg[4] = 4'b0001;
    es[0] = 2'b00;   es[1] = 2'b01;   es[2] = 2'b10;   es[3] = 2'b11;   es[4] = 2'b00;
    do_reset();
    req = 4'b1111; ready = 1'b1; last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (grant !== eg[i] || {s2, s1} !== es[i] || valid !== 1'b1) begin failures++;
        $display("FAIL rot%0d got=%b sel=%b v=%b exp=%b sel=%b v=1", i, grant, {s2, s1}, valid, eg[i], es[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 4'b0010; ready = 1'b0; last = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (grant !== 4'b0010 || valid !== 1'b1 || beat_cnt !== 8'd0) begin failures++;
        $display("FAIL bp_hold%0d got=%b v=%b c=%0d exp=0010 v=1 c=0", i, grant, valid, beat_cnt); end
    end
    req = 4'b0110; ready = 1'b1; last = 1'b1;
    tick();
    checks++; if (grant !== 4'b0100 || {s2, s1} !== 2'b10 || beat_cnt !== 8'd0) begin failures++;
      $display("FAIL bp_release got=%b sel=%b c=%0d exp=0100 sel=10 c=0", grant, {s2, s1}, beat_cnt); end
  endtask

  task automatic test_withdrawal();
    do_reset();
    req = 4'b1000; ready = 1'b1; last = 1'b0;
    tick(); tick(); tick();
    checks++; if (grant !== 4'b1000 || beat_cnt !== 8'd2) begin failures++;
      $display("FAIL wd_pre got=%b c=%0d exp=1000 c=2", grant, beat_cnt); end
    req = 4'b0001; ready = 1'b0;
    tick();
    checks++; if (grant !== 4'b0001 || {s2, s1} !== 2'b00 || beat_cnt !== 8'd0 || valid !== 1'b1) begin failures++;
      $display("FAIL wd_switch got=%b sel=%b c=%0d v=%b exp=0001 sel=00 c=0 v=1", grant, {s2, s1}, beat_cnt, valid); end
  endtask

  task automatic test_max1();
    logic [3:0] eg [0:3];
    eg[0] = 4'b0001; eg[1] = 4'b0010; eg[2] = 4'b0001; eg[3] = 4'b0010;
    do_reset();
    req1 = 4'b0011; ready1 = 1'b1; last1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (grant1 !== eg[i] || beat_cnt1 !== 8'd0 || valid1 !== 1'b1) begin failures++;
        $display("FAIL max1_%0d got=%b c=%0d v=%b exp=%b c=0 v=1", i, grant1, beat_cnt1, valid1, eg[i]); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req = 4'b0; last = 1'b0; ready = 1'b0;
    req1 = 4'b0; last1 = 1'b0; ready1 = 1'b0;
    #2;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_withdrawal();
    test_max1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
